// File: rtl/cpu_run_ctrl_if.sv
// Run-control signal bundle between the test harness and cpu_run_ctrl.
// master: harness side (drives start/step/CPU status); slave: controller side.
// Signals: start, step_mode, step, regPC, inst -> controller;
//          initPC, cpu_en, busy, done, halt_cause, cycle_cnt, last_pc <- controller.
interface cpu_run_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             step_mode;
    logic             step;
    logic [31:0]      regPC;
    logic [31:0]      inst;
    logic             initPC;
    logic             cpu_en;
    logic             busy;
    logic             done;
    logic [2:0]       halt_cause;
    logic [CNT_W-1:0] cycle_cnt;
    logic [31:0]      last_pc;

    modport master (
        output start, step_mode, step, regPC, inst,
        input  initPC, cpu_en, busy, done, halt_cause, cycle_cnt, last_pc
    );

    modport slave (
        input  start, step_mode, step, regPC, inst,
        output initPC, cpu_en, busy, done, halt_cause, cycle_cnt, last_pc
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle CPU: PC init strobe, clock-enable gating, halt detection.
// Latency: all outputs registered; halt decided and cpu_en dropped at the halting enabled edge.
// Backpressure: none; step_mode=1 holds the CPU until a step pulse, start ignored while busy.
//
// Ports: clk, rst_n (async active-low); bus (cpu_run_ctrl_if.slave):
//   in : start, step_mode, step, regPC, inst
//   out: initPC, cpu_en, busy, done, halt_cause, cycle_cnt, last_pc
// Optional macro HALT_INST_EN: adds the halt-instruction check (cause 4, highest priority).
module cpu_run_ctrl #(
    parameter int          INIT_CYCLES = 1,
    parameter int          MAX_CYCLES  = 64,
    parameter int          CNT_W       = 16,
    parameter logic [31:0] HALT_ADDR   = 32'hFFFF_FFFC,
    parameter int          STALL_LIMIT = 3,
    parameter logic [31:0] HALT_INST   = 32'h0000_000C
) (
    input  logic          clk,
    input  logic          rst_n,
    cpu_run_ctrl_if.slave bus
);
    localparam int IW = $clog2(INIT_CYCLES + 1);
    localparam int SW = $clog2(STALL_LIMIT + 1);

    localparam logic [IW-1:0]    INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [SW-1:0]    STALL_LIM = SW'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_CYCLES);

    localparam logic [2:0] CAUSE_NONE   = 3'd0;
    localparam logic [2:0] CAUSE_ADDR   = 3'd1;
    localparam logic [2:0] CAUSE_STALL  = 3'd2;
    localparam logic [2:0] CAUSE_BUDGET = 3'd3;
    localparam logic [2:0] CAUSE_INST   = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state,     w_state_nxt;
    logic [IW-1:0]    r_init_cnt,  w_init_nxt;
    logic [SW-1:0]    r_stall_cnt, w_stall_nxt;
    logic             r_initPC,    w_initPC_nxt;
    logic             r_cpu_en,    w_cpu_en_nxt;
    logic             r_busy,      w_busy_nxt;
    logic             r_done,      w_done_nxt;
    logic [2:0]       r_cause,     w_cause_nxt;
    logic [CNT_W-1:0] r_cycle_cnt, w_cnt_nxt;
    logic [31:0]      r_last_pc,   w_last_pc_nxt;

    // Post-update values of this enabled edge; halt checks look at these.
    logic [CNT_W-1:0] w_cnt_inc;
    logic [SW-1:0]    w_stall_inc;
    logic             w_hit_inst;
    logic [2:0]       w_halt_cause;

    assign w_cnt_inc   = r_cycle_cnt + 1'b1;
    assign w_stall_inc = (bus.regPC == r_last_pc) ? r_stall_cnt + 1'b1 : '0;

`ifdef HALT_INST_EN
    assign w_hit_inst = (bus.inst == HALT_INST);
`else
    logic w_unused_inst;
    assign w_hit_inst    = 1'b0;
    assign w_unused_inst = ^{bus.inst, HALT_INST};
`endif

    // Fixed priority: instruction, address, stall, budget.
    always_comb begin
        w_halt_cause = CAUSE_NONE;
        if (w_hit_inst)
            w_halt_cause = CAUSE_INST;
        else if (bus.regPC == HALT_ADDR)
            w_halt_cause = CAUSE_ADDR;
        else if (w_stall_inc >= STALL_LIM)
            w_halt_cause = CAUSE_STALL;
        else if (w_cnt_inc == MAX_CNT)
            w_halt_cause = CAUSE_BUDGET;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_init_nxt    = r_init_cnt;
        w_stall_nxt   = r_stall_cnt;
        w_initPC_nxt  = r_initPC;
        w_cpu_en_nxt  = r_cpu_en;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_done;
        w_cause_nxt   = r_cause;
        w_cnt_nxt     = r_cycle_cnt;
        w_last_pc_nxt = r_last_pc;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_nxt   = S_INIT;
                    w_init_nxt    = '0;
                    w_stall_nxt   = '0;
                    w_initPC_nxt  = 1'b1;
                    w_cpu_en_nxt  = 1'b1;
                    w_busy_nxt    = 1'b1;
                    w_done_nxt    = 1'b0;
                    w_cause_nxt   = CAUSE_NONE;
                    w_cnt_nxt     = '0;
                    w_last_pc_nxt = '0;
                end
            end

            // cpu_en is always high here, so every edge is an enabled init edge.
            S_INIT: begin
                if (r_init_cnt == INIT_LAST) begin
                    w_state_nxt  = S_RUN;
                    w_init_nxt   = '0;
                    w_initPC_nxt = 1'b0;
                    w_cpu_en_nxt = !bus.step_mode;
                end else begin
                    w_init_nxt = r_init_cnt + 1'b1;
                end
            end

            S_RUN: begin
                // Free-run, or a one-cycle pulse per step seen while the CPU is held.
                w_cpu_en_nxt = !bus.step_mode || (bus.step && !r_cpu_en);
                if (r_cpu_en) begin
                    w_cnt_nxt     = w_cnt_inc;
                    w_last_pc_nxt = bus.regPC;
                    w_stall_nxt   = w_stall_inc;
                    if (w_halt_cause != CAUSE_NONE) begin
                        w_state_nxt  = S_DONE;
                        w_cpu_en_nxt = 1'b0;
                        w_busy_nxt   = 1'b0;
                        w_done_nxt   = 1'b1;
                        w_cause_nxt  = w_halt_cause;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_init_cnt  <= '0;
            r_stall_cnt <= '0;
            r_initPC    <= 1'b0;
            r_cpu_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cause     <= CAUSE_NONE;
            r_cycle_cnt <= '0;
            r_last_pc   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_cnt  <= w_init_nxt;
            r_stall_cnt <= w_stall_nxt;
            r_initPC    <= w_initPC_nxt;
            r_cpu_en    <= w_cpu_en_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_cause     <= w_cause_nxt;
            r_cycle_cnt <= w_cnt_nxt;
            r_last_pc   <= w_last_pc_nxt;
        end
    end

    assign bus.initPC     = r_initPC;
    assign bus.cpu_en     = r_cpu_en;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.halt_cause = r_cause;
    assign bus.cycle_cnt  = r_cycle_cnt;
    assign bus.last_pc    = r_last_pc;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Synthesizable run controller for the single-cycle CPU: sequences PC initialisation, gates CPU execution with a clock enable, and stops the run on a halt condition.
- Generalises the fixed init-pulse/fixed-cycle-count run used for CPU bring-up:
  - parametrised init length and cycle budget;
  - halt-address and branch-to-self detection;
  - single-step mode;
  - cycle/PC status outputs.
- Sits between the top-level test harness and the CPU's clk/initPC inputs.

Parameters:
- INIT_CYCLES, 1, number of enabled cycles initPC is held high after start (>=1)
- MAX_CYCLES, 64, run budget in enabled RUN cycles before forced stop (>=1)
- CNT_W, 16, width of cycle counter (2^CNT_W-1 >= MAX_CYCLES)
- HALT_ADDR, 32'hFFFF_FFFC, PC value that ends the run
- STALL_LIMIT, 3, consecutive enabled cycles with unchanged PC that end the run (>=1)
- HALT_INST, 32'h0000_000C, instruction word that ends the run (only with HALT_INST_EN)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle run request; honoured only in IDLE or DONE
- step_mode  in  1  1 = RUN advances one cycle per step pulse; sampled every cycle
- step  in  1  single-step request pulse
- regPC  in  32  current CPU PC
- inst  in  32  current CPU instruction
- initPC  out  1  PC-initialise strobe to CPU
- cpu_en  out  1  CPU clock/write enable
- busy  out  1  high in INIT and RUN
- done  out  1  high in DONE
- halt_cause  out  3  0 none, 1 halt addr, 2 stall, 3 budget, 4 halt inst
- cycle_cnt  out  CNT_W  enabled RUN cycles executed this run
- last_pc  out  32  regPC captured at the most recent enabled RUN edge

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE;
  - all outputs 0;
  - internal init and stall counters 0.
- All outputs are registered.
- An "enabled edge" is a rising clk edge at which cpu_en is 1.
- IDLE: start=1 -> INIT next edge. At that edge:
  - initPC<=1, cpu_en<=1, busy<=1;
  - cycle_cnt, halt_cause, last_pc and the stall counter <=0.
- INIT: initPC and cpu_en stay high for exactly INIT_CYCLES enabled edges, then RUN. On that edge initPC<=0. cycle_cnt does not count init cycles.
- RUN, step_mode=0: cpu_en=1 every cycle.
- RUN, step_mode=1: cpu_en pulses high for exactly one cycle, on the cycle after each step=1 sample.
  - A step arriving while that pulse is high is ignored.
  - Changing step_mode mid-run takes effect at the next cycle boundary.
- At each enabled RUN edge:
  - cycle_cnt+=1;
  - last_pc<=regPC;
  - stall counter +1 if regPC==last_pc, else cleared to 0.
- Halt checks use post-update values at the same edge. Priority is: inst, then addr, then stall, then budget.
  - Halt inst: inst==HALT_INST (HALT_INST_EN only) -> cause 4.
  - Halt addr: regPC==HALT_ADDR -> cause 1.
  - Stall: stall counter reaches STALL_LIMIT -> cause 2.
  - Budget: cycle_cnt reaches MAX_CYCLES -> cause 3.
- When any halt fires: DONE at the same edge; cpu_en<=0, busy<=0, done<=1, halt_cause latched.
- Exactly cycle_cnt CPU cycles have executed when done rises. No extra cpu_en cycle follows the halting edge.
- DONE: done, halt_cause, cycle_cnt and last_pc hold. start=1 -> INIT with done<=0, same clearing as from IDLE.
- start while busy is ignored. step outside RUN is ignored.
- Reset mid-INIT or mid-RUN: immediate return to reset values. No further cpu_en.

Optional Feature:
- Macro HALT_INST_EN.
- Defined: adds the halt-instruction check (cause 4, highest priority).
- Undefined: HALT_INST is unused, cause 4 is never produced, and the inst port is present but ignored.

Test Plan:
- INIT_CYCLES=2: start, with regPC incrementing 0,4,8.. -> initPC high exactly 2 cycles, then RUN. After 64 enabled edges: done=1, halt_cause=3, cycle_cnt=64, last_pc=32'h0FC.
- regPC sequence 0,4,8,8,8,8 (branch-to-self) with STALL_LIMIT=3 -> done at 6th RUN edge, cause 2, last_pc=8, cpu_en low the following cycle.
- regPC reaches 32'hFFFF_FFFC on cycle 5 -> cause 1, cycle_cnt=5. If the stall condition fires on the same edge, cause is still 1.
- step_mode=1 with 3 step pulses spaced 4 cycles apart -> exactly 3 single-cycle cpu_en pulses, cycle_cnt=3. A step during the cpu_en pulse adds no cycle.
- rst_n low during RUN at cycle 10 -> all outputs 0 immediately. A later start restarts from INIT with cycle_cnt=0. A start pulse during RUN is ignored.
- HALT_INST_EN defined, inst=32'h0000_000C at cycle 7 -> cause 4, cycle_cnt=7. Same stimulus without the macro -> run continues to the budget halt (cause 3).
